// File: rtl/ap_engine_p.sv
// ap_engine_p - bit-serial associative processor.
//
// Three CAM-style columns A, B (WORD_SIZE bits) and C (WORD_SIZE+1 bits,
// C[WORD_SIZE] = carry/borrow) across CELL_QUANT rows. Every bit-step runs a
// series of passes. Each pass covers one input combination (x, y, cin) and
// takes two cycles: COMPARE tags the matching rows, then WRITE stores the
// truth-table output into those rows.
//
// Ports:
//   CLK100MHZ     clock, rising edge
//   rst           synchronous active-high reset
//   addr_in       host row address
//   data_in       host write data (A/B use [WORD_SIZE-1:0])
//   sel_col       0=A 1=B 2=C 3=row-enable
//   write_en      host write strobe (ignored while busy)
//   read_en       host read strobe (ignored while busy); data_out next cycle
//   data_out      registered read data, holds between reads
//   cmd           0 OR, 1 XOR, 2 AND, 3 NOT(A), 4 ADD, 5 SUB, 6 MUL, 7 no-op
//   start         one-cycle launch pulse, accepted in IDLE only
//   busy          operation in progress
//   ap_state_irq  sticky completion flag, cleared by the next accepted start
//
// Optional feature: define AP_ROW_ENABLE_EN to add a per-row enable register
// (sel_col = 3). Disabled rows never tag.
module ap_engine_p #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CELL_QUANT = 64,
    parameter int unsigned MULT_BITS  = 4,
    localparam int unsigned AW = $clog2(CELL_QUANT)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [AW-1:0]        addr_in,
    input  logic [WORD_SIZE:0]   data_in,
    input  logic [1:0]           sel_col,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [WORD_SIZE:0]   data_out,
    input  logic [2:0]           cmd,
    input  logic                 start,
    output logic                 busy,
    output logic                 ap_state_irq
);

    localparam int unsigned IW = $clog2(WORD_SIZE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] CMD_OR  = 3'd0;
    localparam logic [2:0] CMD_XOR = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_NOT = 3'd3;
    localparam logic [2:0] CMD_SUB = 3'd5;
    localparam logic [2:0] CMD_MUL = 3'd6;
    localparam logic [2:0] CMD_NOP = 3'd7;

    localparam logic [IW-1:0] K_LAST = IW'(WORD_SIZE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(MULT_BITS);
    localparam logic [IW-1:0] J_LAST = IW'(MULT_BITS - 1);

    logic [2:0]           r_state;
    logic [2:0]           r_cmd;
    logic [2:0]           r_pass;
    logic [IW-1:0]        r_bi;      // bit index k (or multiplicand index i)
    logic [IW-1:0]        r_bj;      // multiplier index j, 0 for non-MUL
    logic                 r_busy;
    logic                 r_irq;
    logic [WORD_SIZE:0]   r_dout;
    logic [WORD_SIZE-1:0] r_a [CELL_QUANT];
    logic [WORD_SIZE-1:0] r_b [CELL_QUANT];
    logic [WORD_SIZE:0]   r_c [CELL_QUANT];
    logic [CELL_QUANT-1:0] r_tag;
    logic [CELL_QUANT-1:0] r_visited;
    logic [CELL_QUANT-1:0] w_row_en;

`ifdef AP_ROW_ENABLE_EN
    logic [CELL_QUANT-1:0] r_row_en;
    assign w_row_en = r_row_en;
`else
    assign w_row_en = '1;
`endif

    logic                 w_logic;
    logic                 w_mul;
    logic [IW-1:0]        w_t;
    logic                 w_px, w_py, w_pc;
    logic                 w_res, w_carry;
    logic                 w_last_pass, w_last_step, w_new_j;
    logic [CELL_QUANT-1:0] w_match;
    logic [WORD_SIZE-1:0] w_sa, w_sb, w_sbj;
    logic [WORD_SIZE:0]   w_sc;
    logic                 w_x, w_y;

    assign data_out     = r_dout;
    assign busy         = r_busy;
    assign ap_state_irq = r_irq;

    assign w_logic = ~r_cmd[2];
    assign w_mul   = (r_cmd == CMD_MUL);
    assign w_t     = r_bi + r_bj;

    // Pass combination and the truth-table outputs written for it.
    // Logic ops enumerate only (x, y); arithmetic ops enumerate (x, y, cin).
    always_comb begin
        w_px    = w_logic ? r_pass[1] : r_pass[2];
        w_py    = w_logic ? r_pass[0] : r_pass[1];
        w_pc    = r_pass[0];
        w_res   = w_px ^ w_py ^ w_pc;
        w_carry = (w_px & w_py) | (w_pc & (w_px ^ w_py));
        case (r_cmd)
            CMD_OR:  w_res = w_px | w_py;
            CMD_XOR: w_res = w_px ^ w_py;
            CMD_AND: w_res = w_px & w_py;
            CMD_NOT: w_res = ~w_px;
            CMD_SUB: w_carry = (~w_px & w_py) | (~(w_px ^ w_py) & w_pc);
            default: ;
        endcase
        w_last_pass = w_logic ? (r_pass == 3'd3) : (r_pass == 3'd7);
        w_last_step = w_mul ? ((r_bi == I_LAST) && (r_bj == J_LAST))
                            : (r_bi == K_LAST);
        w_new_j     = w_mul && (r_bi == I_LAST);
    end

    // Per-row compare against the current combination. For MUL, x is the
    // partial-product bit A[i]&B[j] (0 on the extra carry-flush step i=MULT_BITS)
    // and y is the running accumulator bit C[i+j].
    always_comb begin
        w_match = '0;
        w_sa    = '0;
        w_sb    = '0;
        w_sbj   = '0;
        w_sc    = '0;
        w_x     = 1'b0;
        w_y     = 1'b0;
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            w_sa  = r_a[r] >> r_bi;
            w_sb  = r_b[r] >> r_bi;
            w_sbj = r_b[r] >> r_bj;
            w_sc  = r_c[r] >> w_t;
            w_x   = w_mul ? ((r_bi < I_LAST) & w_sa[0] & w_sbj[0]) : w_sa[0];
            w_y   = w_mul ? w_sc[0] : w_sb[0];
            w_match[r] = (w_x == w_px) && (w_y == w_py)
                      && (w_logic || (r_c[r][WORD_SIZE] == w_pc))
                      && !r_visited[r] && w_row_en[r];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_pass    <= '0;
            r_bi      <= '0;
            r_bj      <= '0;
            r_busy    <= 1'b0;
            r_irq     <= 1'b0;
            r_dout    <= '0;
            r_tag     <= '0;
            r_visited <= '0;
`ifdef AP_ROW_ENABLE_EN
            r_row_en  <= '1;
`endif
            for (int unsigned r = 0; r < CELL_QUANT; r++) begin
                r_a[r] <= '0;
                r_b[r] <= '0;
                r_c[r] <= '0;
            end
        end else begin
            // Host port; the read samples pre-edge contents, so a same-cycle
            // write to the same location returns the old value.
            if (!r_busy) begin
                if (write_en) begin
                    case (sel_col)
                        2'd0: r_a[addr_in] <= data_in[WORD_SIZE-1:0];
                        2'd1: r_b[addr_in] <= data_in[WORD_SIZE-1:0];
                        2'd2: r_c[addr_in] <= data_in;
                        default: begin
`ifdef AP_ROW_ENABLE_EN
                            r_row_en[addr_in] <= data_in[0];
`endif
                        end
                    endcase
                end
                if (read_en) begin
                    case (sel_col)
                        2'd0: r_dout <= {1'b0, r_a[addr_in]};
                        2'd1: r_dout <= {1'b0, r_b[addr_in]};
                        2'd2: r_dout <= r_c[addr_in];
                        default: begin
`ifdef AP_ROW_ENABLE_EN
                            r_dout <= {{WORD_SIZE{1'b0}}, r_row_en[addr_in]};
`else
                            r_dout <= '0;
`endif
                        end
                    endcase
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cmd   <= cmd;
                        r_busy  <= 1'b1;
                        r_irq   <= 1'b0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    for (int unsigned r = 0; r < CELL_QUANT; r++) begin
                        r_c[r] <= '0;
                    end
                    r_pass    <= '0;
                    r_bi      <= '0;
                    r_bj      <= '0;
                    r_visited <= '0;
                    if (r_cmd == CMD_NOP) begin
                        r_busy  <= 1'b0;
                        r_irq   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_tag   <= w_match;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    for (int unsigned r = 0; r < CELL_QUANT; r++) begin
                        if (r_tag[r]) begin
                            r_c[r][w_t] <= w_res;
                            if (!w_logic) begin
                                r_c[r][WORD_SIZE] <= w_carry;
                            end
                        end
                        // New multiplier bit: restart the carry chain. Placed
                        // after the tagged write so it takes precedence.
                        if (w_last_pass && w_new_j && !w_last_step) begin
                            r_c[r][WORD_SIZE] <= 1'b0;
                        end
                    end
                    if (w_last_pass) begin
                        r_pass    <= '0;
                        r_visited <= '0;
                        if (w_last_step) begin
                            r_busy  <= 1'b0;
                            r_irq   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            if (w_new_j) begin
                                r_bi <= '0;
                                r_bj <= r_bj + IW'(1);
                            end else begin
                                r_bi <= r_bi + IW'(1);
                            end
                            r_state <= S_COMPARE;
                        end
                    end else begin
                        r_pass    <= r_pass + 3'd1;
                        r_visited <= r_visited | r_tag;
                        r_state   <= S_COMPARE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_engine_p.sv
// Directed self-checking bench for ap_engine_p (default parameters).
module tb_ap_engine_p;

    logic       clk;
    logic       rst;
    logic [5:0] addr_in;
    logic [8:0] data_in;
    logic [1:0] sel_col;
    logic       write_en;
    logic       read_en;
    logic [8:0] data_out;
    logic [2:0] cmd;
    logic       start;
    logic       busy;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ap_engine_p #(.WORD_SIZE(8), .CELL_QUANT(64), .MULT_BITS(4)) dut (
        .CLK100MHZ    (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .sel_col      (sel_col),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_out     (data_out),
        .cmd          (cmd),
        .start        (start),
        .busy         (busy),
        .ap_state_irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]       cmd;
        logic [3:0][7:0]  a;     // {row3,row2,row1,row0}
        logic [3:0][7:0]  b;
        logic [3:0][8:0]  c;     // expected C
        int               lat;   // edges from start acceptance to irq
        string            name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] col, input int row, input logic [8:0] d);
        sel_col  = col;
        addr_in  = 6'(row);
        data_in  = d;
        write_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] col, input int row, output logic [8:0] d);
        sel_col = col;
        addr_in = 6'(row);
        read_en = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b0;
        d = data_out;
    endtask

    task automatic start_op(input logic [2:0] c, input string name);
        cmd   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        check({name, " busy@1"}, 32'(busy), 32'd1);
        check({name, " irq cleared"}, 32'(irq), 32'd0);
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        while (!irq && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [8:0] rd;
    logic [8:0] exp2;

    initial begin
        // Logic ops: rows 0..3 A = F0,0F,AA,FF; B = 3C
        vecs[0] = '{3'd0, {8'hFF, 8'hAA, 8'h0F, 8'hF0}, {4{8'h3C}},
                    {9'h0FF, 9'h0BE, 9'h03F, 9'h0FC}, 66, "OR"};
        vecs[1] = '{3'd1, {8'hFF, 8'hAA, 8'h0F, 8'hF0}, {4{8'h3C}},
                    {9'h0C3, 9'h096, 9'h033, 9'h0CC}, 66, "XOR"};
        vecs[2] = '{3'd2, {8'hFF, 8'hAA, 8'h0F, 8'hF0}, {4{8'h3C}},
                    {9'h03C, 9'h028, 9'h00C, 9'h030}, 66, "AND"};
        vecs[3] = '{3'd3, {8'hFF, 8'hAA, 8'h0F, 8'hF0}, {4{8'h3C}},
                    {9'h000, 9'h055, 9'h0F0, 9'h00F}, 66, "NOT"};
        vecs[4] = '{3'd4, {8'h00, 8'hFF, 8'h05, 8'hC8}, {8'h00, 8'h01, 8'h07, 8'h64},
                    {9'h000, 9'h100, 9'h00C, 9'h12C}, 130, "ADD"};
        vecs[5] = '{3'd5, {8'h00, 8'h80, 8'h07, 8'h05}, {8'h01, 8'h80, 8'h05, 8'h07},
                    {9'h1FF, 9'h000, 9'h002, 9'h1FE}, 130, "SUB"};
        vecs[6] = '{3'd6, {8'h0C, 8'h00, 8'hF3, 8'h0F}, {8'h0B, 8'h09, 8'h02, 8'h0F},
                    {9'h084, 9'h000, 9'h006, 9'h0E1}, 322, "MUL"};
        vecs[7] = '{3'd7, {8'h11, 8'h22, 8'h33, 8'h44}, {8'h55, 8'h66, 8'h77, 8'h88},
                    {9'h000, 9'h000, 9'h000, 9'h000}, 2, "NOP"};

        rst = 1'b1; addr_in = '0; data_in = '0; sel_col = '0;
        write_en = 1'b0; read_en = 1'b0; cmd = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset busy", 32'(busy), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        host_rd(2'd0, 0, rd);  check("reset A[0]", 32'(rd), 32'd0);
        host_rd(2'd2, 63, rd); check("reset C[63]", 32'(rd), 32'd0);

        // Same-cycle write and read of one location returns the old value
        host_wr(2'd0, 7, 9'h011);
        sel_col = 2'd0; addr_in = 6'd7; data_in = 9'h022;
        write_en = 1'b1; read_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0; read_en = 1'b0;
        check("rd/wr old value", 32'(data_out), 32'h011);
        host_rd(2'd0, 7, rd); check("rd/wr new value", 32'(rd), 32'h022);

        // Table-driven operations; C is preloaded with junk that INIT must clear
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < 4; r++) begin
                host_wr(2'd0, r, {1'b0, vecs[v].a[r]});
                host_wr(2'd1, r, {1'b0, vecs[v].b[r]});
                host_wr(2'd2, r, 9'h155);
            end
            start_op(vecs[v].cmd, vecs[v].name);
            wait_done(vecs[v].lat, vecs[v].name);
            for (int r = 0; r < 4; r++) begin
                host_rd(2'd2, r, rd);
                check($sformatf("%s C row%0d", vecs[v].name, r), 32'(rd), 32'(vecs[v].c[r]));
            end
            host_rd(2'd0, 0, rd);
            check({vecs[v].name, " A row0 kept"}, 32'(rd), 32'(vecs[v].a[0]));
        end

        // Host access and start are ignored while busy
        host_wr(2'd0, 0, 9'h001);
        host_wr(2'd1, 0, 9'h002);
        host_rd(2'd0, 0, rd);
        start_op(3'd4, "BUSYADD");
        repeat (3) begin @(posedge clk); #1; cyc++; end
        sel_col = 2'd0; addr_in = 6'd0; data_in = 9'h055;
        start = 1'b1; write_en = 1'b1;
        @(posedge clk); #1; cyc++;
        start = 1'b0; sel_col = 2'd1; data_in = 9'h077; read_en = 1'b1;
        @(posedge clk); #1; cyc++;
        write_en = 1'b0; read_en = 1'b0;
        check("busy read ignored", 32'(data_out), 32'h001);
        wait_done(130, "BUSYADD");
        host_rd(2'd0, 0, rd); check("busy A unchanged", 32'(rd), 32'h001);
        host_rd(2'd1, 0, rd); check("busy B unchanged", 32'(rd), 32'h002);
        host_rd(2'd2, 0, rd); check("busy C result", 32'(rd), 32'h003);

        // Reset in the middle of an ADD
        start_op(3'd4, "RSTADD");
        while (cyc < 40) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst irq", 32'(irq), 32'd0);
        check("midrst data_out", 32'(data_out), 32'd0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                host_rd(2'(c), r, rd);
                check($sformatf("midrst col%0d row%0d", c, r), 32'(rd), 32'd0);
            end
        end

        // Row-enable column
`ifdef AP_ROW_ENABLE_EN
        host_rd(2'd3, 2, rd); check("row_en reset", 32'(rd), 32'd1);
        host_wr(2'd3, 2, 9'h000);
        host_rd(2'd3, 2, rd); check("row_en cleared", 32'(rd), 32'd0);
        exp2 = 9'h000;
`else
        host_wr(2'd3, 2, 9'h001);
        host_rd(2'd3, 2, rd); check("row_en absent", 32'(rd), 32'd0);
        exp2 = 9'h0BE;
`endif
        for (int r = 0; r < 4; r++) begin
            host_wr(2'd0, r, {1'b0, vecs[0].a[r]});
            host_wr(2'd1, r, {1'b0, vecs[0].b[r]});
            host_wr(2'd2, r, 9'h155);
        end
        start_op(3'd0, "ENOR");
        wait_done(66, "ENOR");
        for (int r = 0; r < 4; r++) begin
            host_rd(2'd2, r, rd);
            check($sformatf("ENOR C row%0d", r), 32'(rd),
                  (r == 2) ? 32'(exp2) : 32'(vecs[0].c[r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
